// File: rtl/kbtime_pkg.sv
// Scan-code constants, entry FSM state encoding and digit decoding shared by
// the keyboard time/alarm entry controller.
package kbtime_pkg;

    localparam logic [7:0] SC_0     = 8'h45;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_7     = 8'h3D;
    localparam logic [7:0] SC_8     = 8'h3E;
    localparam logic [7:0] SC_9     = 8'h46;
    localparam logic [7:0] SC_T     = 8'h2C;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SET_TIME  = 2'd1,
        ST_SET_ALARM = 2'd2
    } kb_state_t;

    // Returns {valid, bcd}; valid is 0 for any non-digit code.
    function automatic logic [4:0] digit_decode(input logic [7:0] code);
        case (code)
            SC_0:    digit_decode = {1'b1, 4'd0};
            SC_1:    digit_decode = {1'b1, 4'd1};
            SC_2:    digit_decode = {1'b1, 4'd2};
            SC_3:    digit_decode = {1'b1, 4'd3};
            SC_4:    digit_decode = {1'b1, 4'd4};
            SC_5:    digit_decode = {1'b1, 4'd5};
            SC_6:    digit_decode = {1'b1, 4'd6};
            SC_7:    digit_decode = {1'b1, 4'd7};
            SC_8:    digit_decode = {1'b1, 4'd8};
            SC_9:    digit_decode = {1'b1, 4'd9};
            default: digit_decode = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// PS/2 FIFO pop handshake plus break/extended prefix filtering; emits one
// key_v pulse per make code (extended codes other than Enter are dropped).
module ps2_make_filter
    import kbtime_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    output logic       kb_nextdata_n,
    output logic       key_v,
    output logic [7:0] key_code
);

    logic [7:0] byte_q;
    logic       byte_v;
    logic       brk;
    logic       ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kb_nextdata_n <= 1'b1;
            byte_q        <= 8'h00;
            byte_v        <= 1'b0;
            brk           <= 1'b0;
            ext           <= 1'b0;
            key_v         <= 1'b0;
            key_code      <= 8'h00;
        end else begin
            kb_nextdata_n <= 1'b1;
            byte_v        <= 1'b0;
            key_v         <= 1'b0;
            // A pop in flight blocks the next accept, spacing accepts 2 cycles apart.
            if (kb_ready && kb_nextdata_n) begin
                byte_q        <= kb_data;
                byte_v        <= 1'b1;
                kb_nextdata_n <= 1'b0;
            end
            if (byte_v) begin
                if (byte_q == SC_BRK) begin
                    brk <= 1'b1;
                end else if (byte_q == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    if (!brk && (!ext || byte_q == SC_ENTER)) begin
                        key_v    <= 1'b1;
                        key_code <= byte_q;
                    end
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/kb_time_entry.sv
// Keyboard time/alarm entry controller: collects BCD digits, range-checks on
// Enter and strobes commits. Optional idle timeout: KB_TIME_ENTRY_TIMEOUT_EN.
//
// state        | meaning
// ST_IDLE      | no entry in progress, waiting for T or A
// ST_SET_TIME  | collecting digits for the clock core
// ST_SET_ALARM | collecting digits for alarm channel alarm_sel
module kb_time_entry
    import kbtime_pkg::*;
#(
    parameter  int NUM_DIGITS     = 6,
    parameter  int NUM_ALARMS     = 4,
    parameter  int TIMEOUT_CYCLES = 500000000,
    localparam int AW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int BW             = 4 * NUM_DIGITS
) (
    input  logic          CLK_50,
    input  logic          rst,
    input  logic [7:0]    kb_data,
    input  logic          kb_ready,
    output logic          kb_nextdata_n,
    output logic          set_en,
    output logic          alarm_en,
    output logic [AW-1:0] alarm_sel,
    output logic [BW-1:0] entry_bcd,
    output logic [2:0]    digit_cnt,
    output logic [BW-1:0] value_bcd,
    output logic          commit_time,
    output logic          commit_alarm,
    output logic          entry_err
);

    if ((NUM_DIGITS != 4 && NUM_DIGITS != 6) || NUM_ALARMS < 1 || NUM_ALARMS > 8
        || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("kb_time_entry: illegal parameter value");
    end

    logic       key_v;
    logic [7:0] key_code;
    logic [4:0] digit;
    logic [7:0] hh, mm, ss;
    logic       entry_ok;
    logic       timeout;
    kb_state_t  state;

    ps2_make_filter u_filter (
        .clk           (CLK_50),
        .rst           (rst),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_nextdata_n (kb_nextdata_n),
        .key_v         (key_v),
        .key_code      (key_code)
    );

    assign digit = digit_decode(key_code);

    // Digits are always 0-9, so packed-BCD magnitude compare equals numeric compare.
    assign hh = entry_bcd[BW-1 -: 8];
    assign mm = entry_bcd[BW-9 -: 8];
    assign ss = entry_bcd[7:0];

    always_comb begin
        entry_ok = (digit_cnt == 3'(NUM_DIGITS)) && (hh <= 8'h23) && (mm <= 8'h59);
        if (NUM_DIGITS == 6) entry_ok = entry_ok && (ss <= 8'h59);
    end

`ifdef KB_TIME_ENTRY_TIMEOUT_EN
    logic [28:0] idle_cnt;

    assign timeout = (idle_cnt == 29'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == ST_IDLE || key_v) begin
            idle_cnt <= '0;
        end else if (!timeout) begin
            idle_cnt <= idle_cnt + 29'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK_50 or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            set_en       <= 1'b0;
            alarm_en     <= 1'b0;
            alarm_sel    <= '0;
            entry_bcd    <= '0;
            digit_cnt    <= 3'd0;
            value_bcd    <= '0;
            commit_time  <= 1'b0;
            commit_alarm <= 1'b0;
            entry_err    <= 1'b0;
        end else begin
            commit_time  <= 1'b0;
            commit_alarm <= 1'b0;
            entry_err    <= 1'b0;
            if (timeout && state != ST_IDLE) begin
                state     <= ST_IDLE;
                set_en    <= 1'b0;
                alarm_en  <= 1'b0;
                entry_bcd <= '0;
                digit_cnt <= 3'd0;
            end else if (key_v) begin
                if (state == ST_IDLE) begin
                    if (key_code == SC_T) begin
                        state     <= ST_SET_TIME;
                        set_en    <= 1'b1;
                        alarm_sel <= '0;
                        entry_bcd <= '0;
                        digit_cnt <= 3'd0;
                    end else if (key_code == SC_A) begin
                        state     <= ST_SET_ALARM;
                        alarm_en  <= 1'b1;
                        alarm_sel <= '0;
                        entry_bcd <= '0;
                        digit_cnt <= 3'd0;
                    end
                end else if (digit[4]) begin
                    entry_bcd <= {entry_bcd[BW-5:0], digit[3:0]};
                    if (digit_cnt != 3'(NUM_DIGITS)) digit_cnt <= digit_cnt + 3'd1;
                end else begin
                    case (key_code)
                        SC_BKSP: begin
                            if (digit_cnt != 3'd0) begin
                                entry_bcd <= {4'h0, entry_bcd[BW-1:4]};
                                digit_cnt <= digit_cnt - 3'd1;
                            end
                        end
                        SC_A: begin
                            if (state == ST_SET_ALARM) begin
                                if (alarm_sel == AW'(NUM_ALARMS - 1)) alarm_sel <= '0;
                                else alarm_sel <= alarm_sel + 1'b1;
                            end else begin
                                state     <= ST_SET_ALARM;
                                set_en    <= 1'b0;
                                alarm_en  <= 1'b1;
                                alarm_sel <= '0;
                                entry_bcd <= '0;
                                digit_cnt <= 3'd0;
                            end
                        end
                        SC_T: begin
                            if (state == ST_SET_ALARM) begin
                                state     <= ST_SET_TIME;
                                set_en    <= 1'b1;
                                alarm_en  <= 1'b0;
                                alarm_sel <= '0;
                                entry_bcd <= '0;
                                digit_cnt <= 3'd0;
                            end
                        end
                        SC_ENTER: begin
                            if (entry_ok) begin
                                value_bcd    <= entry_bcd;
                                commit_time  <= (state == ST_SET_TIME);
                                commit_alarm <= (state == ST_SET_ALARM);
                                state        <= ST_IDLE;
                                set_en       <= 1'b0;
                                alarm_en     <= 1'b0;
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end
                        SC_ESC: begin
                            state     <= ST_IDLE;
                            set_en    <= 1'b0;
                            alarm_en  <= 1'b0;
                            entry_bcd <= '0;
                            digit_cnt <= 3'd0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/kb_time_entry.md
Name: kb_time_entry

Overview:
- Keyboard-driven time/alarm entry controller, parametrised successor to the single-mode key-time front end.
- Consumes PS/2 set-2 bytes from ps2_keyboard over its data/ready/nextdata_n handshake and filters break/extended prefixes.
- Collects BCD digits in an N-digit buffer, range-checks them, and emits one-cycle commit strobes for the clock core or for one of several alarm channels.
- Sits between ps2_keyboard and the clock/alarm register blocks; entry_bcd drives the seven-segment display during entry.

Parameters:
- NUM_DIGITS, 6, digits per entry; legal values 4 (HHMM) or 6 (HHMMSS).
- NUM_ALARMS, 4, alarm channels, 1..8; AW = max(1, clog2(NUM_ALARMS)).
- TIMEOUT_CYCLES, 500000000, idle cycles before entry is abandoned (used only with the optional feature).

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- kb_data  in  8  scan byte from ps2_keyboard.
- kb_ready  in  1  ps2_keyboard FIFO non-empty.
- kb_nextdata_n  out  1  active-low pop strobe to ps2_keyboard.
- set_en  out  1  time-set mode active.
- alarm_en  out  1  alarm-set mode active.
- alarm_sel  out  AW  alarm channel being edited.
- entry_bcd  out  4*NUM_DIGITS  live digit buffer; most recent digit in the low nibble.
- digit_cnt  out  3  digits entered, 0..NUM_DIGITS.
- value_bcd  out  4*NUM_DIGITS  last committed value; held until the next commit.
- commit_time  out  1  one-cycle pulse; value_bcd is valid for the clock core.
- commit_alarm  out  1  one-cycle pulse; value_bcd is valid for channel alarm_sel.
- entry_err  out  1  one-cycle pulse on Enter with an incomplete or out-of-range entry.

Behaviour:
- Reset values: all outputs 0 except kb_nextdata_n=1. FSM in IDLE, prefix flags clear.
- Fetch:
  - When kb_ready=1 and no pop is in flight, latch kb_data and drive kb_nextdata_n=0 for exactly one cycle.
  - The latched byte is decoded in the following cycle.
  - Next accept is no earlier than 2 cycles after the previous one.
  - Byte sample to output update: 2 cycles.
- Prefix filter:
  - 0xF0 sets brk; the next byte is discarded and brk clears.
  - 0xE0 sets ext; ext clears after the next byte. Extended Enter (E0 5A) is treated as Enter; other extended codes are ignored.
  - Only make codes produce a key event.
- Key codes:
  - Digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46.
  - T = 2C, A = 1C, Enter = 5A, Esc = 76, Backspace = 66.
  - Any other code is ignored.
- FSM states: IDLE, SET_TIME, SET_ALARM.
- IDLE:
  - T -> SET_TIME; set_en=1; buffer and count cleared.
  - A -> SET_ALARM; alarm_en=1; alarm_sel=0; buffer and count cleared.
  - Digits are ignored.
- SET_TIME / SET_ALARM:
  - Digit: buffer shifts left one nibble, new digit enters the low nibble; digit_cnt saturates at NUM_DIGITS. On overflow the oldest digit drops out.
  - Backspace: buffer shifts right one nibble; digit_cnt decrements with floor 0; no-op at 0.
  - A while in SET_ALARM: alarm_sel increments, wrapping at NUM_ALARMS-1 -> 0. The buffer is kept.
  - T in SET_ALARM, or A in SET_TIME: switch mode, clear buffer, set alarm_sel=0.
  - Enter, valid entry: digit_cnt==NUM_DIGITS, HH<=23, MM<=59, and SS<=59 when NUM_DIGITS=6. Then value_bcd <= entry_bcd, pulse commit_time or commit_alarm, go to IDLE.
  - Enter, invalid entry: pulse entry_err, stay in state, buffer unchanged.
  - Esc: go to IDLE, clear buffer; no strobe.
- In IDLE, set_en and alarm_en are both 0; at most one of them is high at any time.
- commit_time, commit_alarm and entry_err are mutually exclusive.
- An asserted rst mid-entry or mid-pop aborts immediately: kb_nextdata_n returns to 1 and no strobe is emitted.

Optional Feature:
- Macro: KB_TIME_ENTRY_TIMEOUT_EN.
- Enabled: a 29-bit counter clears on every key event and whenever the FSM is in IDLE. When it reaches TIMEOUT_CYCLES-1 in SET_TIME or SET_ALARM, the FSM goes to IDLE and clears the buffer, exactly as for Esc.
- Disabled: no counter is built; entry persists indefinitely.

Decomposition:
- Package kbtime_pkg holds:
  - scan-code localparams (SC_0..SC_9, SC_T, SC_A, SC_ENTER, SC_ESC, SC_BKSP, SC_BRK, SC_EXT);
  - the FSM state encoding;
  - a digit-decode function returning {valid, bcd[3:0]}.
- One sub-module, ps2_make_filter: owns the handshake, pop strobe and prefix flags; outputs a key_v/key_code pair.

Test Plan:
- NUM_DIGITS=4; bytes 2C,16,1E,26,25,5A -> entry_bcd=1234 during entry; commit_time pulses once; value_bcd=16'h1234; set_en falls.
- NUM_DIGITS=6; T,2,5,0,0,0,0,Enter -> entry_err pulses; state stays SET_TIME; Esc -> set_en=0; value_bcd unchanged.
- Bytes 2C,16,F0,16,1E -> only one "1" registered (digit_cnt=2, entry_bcd low byte=12). kb_nextdata_n pulses exactly once per byte.
- NUM_ALARMS=4; A,A,A,A,A -> alarm_sel 0,1,2,3,0. Then A, digits 073000, Enter -> commit_alarm with alarm_sel=1 and value_bcd=24'h073000.
- Enter 1,2,3, Backspace, 4 -> entry_bcd low nibbles = 124. Assert rst mid-entry -> all outputs 0, kb_nextdata_n=1 within the same cycle.
- With KB_TIME_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=100: T, then 100 idle cycles -> set_en=0 and no strobes.
